// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  gt9999;
  logic                  neg;

  modport master (output start, bin, input busy, done, bcd, gt9999, neg);
  modport slave  (input start, bin, output busy, done, bcd, gt9999, neg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement (magnitude + neg flag).
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]   dig_q, dig_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic            gt_q, gt_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    dig_sh;
  logic [WIDTH-1:0] operand;
  logic             sgn_in;

  // Add-3 correction on every digit before the shift keeps each digit in 0..9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (dig_q[4*g +: 4] >= 4'd5) ? dig_q[4*g +: 4] + 4'd3
                                                      : dig_q[4*g +: 4];
  end
  assign dig_sh = {adj[BW-2:0], sr_q[WIDTH-1]};

`ifdef BIN2BCD_SIGNED_EN
  // Unsigned negate: the most negative input maps to magnitude 2^(WIDTH-1).
  assign operand = bus.bin[WIDTH-1] ? (~bus.bin) + WIDTH'(1) : bus.bin;
  assign sgn_in  = bus.bin[WIDTH-1];
`else
  assign operand = bus.bin;
  assign sgn_in  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = operand;
          dig_d   = '0;
          cnt_d   = '0;
          sgn_d   = sgn_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dig_d = dig_sh;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CW'(1);
        // Last shift: publish the result on the same edge so outputs never show partials.
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = dig_sh;
          gt_d    = |dig_sh[BW-1:16];
          neg_d   = sgn_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = done_q;
  assign bus.bcd    = bcd_q;
  assign bus.gt9999 = gt_q;
  assign bus.neg    = neg_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=32, DIGITS=10).
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  bin2bcd_seq_if #(.WIDTH(32), .DIGITS(10)) bus ();
  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion: pulse start, optionally re-pulse start mid-conversion, check latency and result.
  task automatic run(input string tag, input logic [31:0] b, input logic [39:0] exp_bcd,
                     input logic exp_gt, input logic exp_neg, input bit poke);
    logic [39:0] prev;
    logic        prev_gt, prev_neg;
    int          k;
    bit          got = 0, hold_ok = 1, busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = b;
    prev = bus.bcd; prev_gt = bus.gt9999; prev_neg = bus.neg;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = $urandom;
    busy_ok = bus.busy;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin got = 1; break; end
      if (poke && k == 10) begin bus.start = 1'b1; bus.bin = 32'd0; end
      if (poke && k == 11) bus.start = 1'b0;
      if (!bus.busy) busy_ok = 0;
      if (bus.bcd !== prev || bus.gt9999 !== prev_gt || bus.neg !== prev_neg) hold_ok = 0;
    end
    chk({tag, ".latency"}, got ? k : 0, 32);
    chk({tag, ".bcd"}, {24'd0, bus.bcd}, {24'd0, exp_bcd});
    chk({tag, ".gt9999"}, bus.gt9999, exp_gt);
    chk({tag, ".neg"}, bus.neg, exp_neg);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".hold"}, hold_ok, 1);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int  k, d1, d2;
    bit  ok;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.bcd", bus.bcd, 0);
    chk("rst.gt", bus.gt9999, 0);
    chk("rst.neg", bus.neg, 0);
    @(negedge clk); reset = 1'b1;

    run("zero", 32'd0, 40'h0, 1'b0, 1'b0, 0);
    run("d9999", 32'd9999, 40'h9999, 1'b0, 1'b0, 1);
    run("d65535", 32'd65535, 40'h65535, 1'b1, 1'b0, 0);
    run("d12345678", 32'd12345678, 40'h12345678, 1'b1, 1'b0, 0);
`ifdef BIN2BCD_SIGNED_EN
    run("allones", 32'hFFFFFFFF, 40'h1, 1'b0, 1'b1, 0);
    run("minneg", 32'h80000000, 40'h2147483648, 1'b1, 1'b1, 0);
`else
    run("allones", 32'hFFFFFFFF, 40'h4294967295, 1'b1, 1'b0, 0);
    run("bit31", 32'h80000000, 40'h2147483648, 1'b1, 1'b0, 0);
`endif

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clk); bus.start = 1'b1; bus.bin = 32'd777;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.bcd", bus.bcd, 0);
    chk("abort.gt", bus.gt9999, 0);
    chk("abort.neg", bus.neg, 0);
    @(negedge clk); reset = 1'b1;
    ok = 1;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ok = 0;
    end
    chk("abort.quiet", ok, 1);
    run("d42", 32'd42, 40'h42, 1'b0, 1'b0, 0);

    // Back-to-back: start held high, bin changed after the first accept.
    @(negedge clk); bus.start = 1'b1; bus.bin = 32'd1234;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; ok = 1;
    for (k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus.bin = 32'd9999;
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = k;
          chk("b2b.first_bcd", bus.bcd, 40'h1234);
        end else begin
          d2 = k;
          bus.start = 1'b0;
          break;
        end
      end else if (d1 != 0 && bus.bcd !== 40'h1234) ok = 0;
    end
    bus.start = 1'b0;
    chk("b2b.first_done", d1, 32);
    chk("b2b.period", d2 - d1, 33);
    chk("b2b.hold", ok, 1);
    chk("b2b.second_bcd", bus.bcd, 40'h9999);
    chk("b2b.second_gt", bus.gt9999, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 32, binary input width in bits.
REQ-002 Parameter DIGITS, default 10, BCD output digit count; SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  conversion request, sampled on rising edge of clk.
REQ-006 bin  input  WIDTH  binary value, sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse, high in the cycle after the result register updates.
REQ-009 bcd  output  4*DIGITS  result, digit 0 (units) in bits [3:0], registered.
REQ-010 gt9999  output  1  high when any digit at index 4 or above in bcd is nonzero; drives the display over-range indication.
REQ-011 neg  output  1  sign of the last result; constant 0 when BIN2BCD_SIGNED_EN is undefined.

Function
REQ-012 The block SHALL implement iterative double-dabble with two states, IDLE and SHIFT, and a step counter of clog2(WIDTH+1) bits.
REQ-013 IDLE: busy=0; start=1 at an edge -> load shift register with operand, clear scratch digits, counter=0, state SHIFT.
REQ-014 SHIFT: each edge, every scratch digit >=5 has 3 added, then {digits, shift register} shifts left by one bit; counter increments.
REQ-015 After the WIDTH-th shift edge, the block SHALL write the post-shift digits to bcd, update gt9999 and neg, pulse done, and return to IDLE on that same edge.
REQ-016 Latency: start accepted at edge N -> bcd valid and done=1 in the cycle after edge N+WIDTH; busy=1 for the cycles between edges N and N+WIDTH.
REQ-017 Throughput: start high during the done cycle SHALL be accepted at the next edge; one conversion per WIDTH+1 cycles.
REQ-018 start while busy=1 SHALL be ignored; bin changes during SHIFT SHALL NOT affect the result.
REQ-019 bcd, gt9999 and neg SHALL hold the previous result throughout a conversion, with no intermediate values visible to the seven-segment driver.
REQ-020 Every scratch digit SHALL stay within 0..9 after each shift; no digit carry beyond digit DIGITS-1.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, busy=0, done=0, bcd=0, gt9999=0, neg=0, counter=0, scratch=0, including mid-conversion (the conversion is aborted, and no done pulse is produced).
REQ-022 The first start after reset release SHALL convert normally.

Configuration
REQ-023 Macro BIN2BCD_SIGNED_EN defined: bin is two's complement. The operand loaded at accept is |bin|, computed as an unsigned WIDTH-bit negate so that -2^(WIDTH-1) gives magnitude 2^(WIDTH-1). neg = bin[WIDTH-1] is captured at accept and published with the result.
REQ-024 Macro undefined: bin is unsigned, no negate logic is built, and neg is tied to 0; port list is identical in both builds.

Verification
REQ-025 bin=0, start pulse -> done 32 cycles after accept edge, bcd=40'h0, gt9999=0, neg=0.
REQ-026 bin=65535 -> bcd=40'h0000065535, gt9999=1; bin=9999 -> bcd=40'h0000009999, gt9999=0.
REQ-027 bin=32'hFFFFFFFF -> unsigned build bcd=40'h4294967295, neg=0; signed build bcd=40'h1, neg=1; signed bin=32'h80000000 -> bcd=40'h2147483648, neg=1.
REQ-028 start held high, bin=1234, then bin=9999 driven 5 cycles after accept -> first result 40'h1234 with done; done pulses every 33 cycles; bcd stays 40'h1234 during the following conversion until its done.
REQ-029 reset driven low at cycle 10 of a conversion -> busy, done, bcd, gt9999 and neg all 0 asynchronously, with no done pulse; after release, start with bin=42 -> bcd=40'h42 after 32 cycles.
